// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared constants and FSM encoding for the boot stream loader
package prog_loader_pkg;

    localparam int WORD_W          = 32;
    localparam int IMEM_WORD_BYTES = 4;
    localparam int DMEM_WORD_BYTES = 8;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_I_CNT  = 4'd1;
    localparam state_t S_I_WORD = 4'd2;
    localparam state_t S_D_CNT  = 4'd3;
    localparam state_t S_D_LO   = 4'd4;
    localparam state_t S_D_HI   = 4'd5;
    localparam state_t S_CHK    = 4'd6;
    localparam state_t S_DONE   = 4'd7;
    localparam state_t S_ERR    = 4'd8;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - valid/ready word stream feeding the loader
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader_csum.sv
// rtl/prog_loader_csum.sv - running XOR of accepted stream words, cleared at load start
module prog_loader_csum
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              arst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [WORD_W-1:0] data_i,
    output logic [WORD_W-1:0] acc_o
);
    logic [WORD_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = acc_q ^ data_i;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - writes a streamed boot image into imem/dmem, then enables the cpu
// Optional trailing checksum word verified when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               start,
    prog_loader_if.slave       s_if,
    output logic               busy,
    output logic               error,
    output logic               cpu_enable,
    output logic [63:0]        addr_ext,
    output logic               wen_ext,
    output logic               ren_ext,
    output logic [WORD_W-1:0]  wdata_ext,
    output logic [63:0]        addr_ext_2,
    output logic               wen_ext_2,
    output logic               ren_ext_2,
    output logic [63:0]        wdata_ext_2
);
    localparam int IDX_W = ((IMEM_DEPTH > DMEM_DEPTH) ? $clog2(IMEM_DEPTH) : $clog2(DMEM_DEPTH)) + 1;

    state_t             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
    logic [WORD_W-1:0]  lo_q, lo_d;
    logic [63:0]        addr_q, addr_d, addr2_q, addr2_d, wdata2_q, wdata2_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic               wen_q, wen_d, wen2_q, wen2_d;
    logic               beat, last;
    state_t             s_final;

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign beat    = s_if.in_valid && s_if.in_ready;
    assign idx_inc = idx_q + 1'b1;
    assign last    = (32'(idx_inc) == cnt_q);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] acc;

    // The CSUM word itself must not fold into the accumulator it is checked against.
    prog_loader_csum u_csum (
        .clk    (clk),
        .arst   (arst),
        .clr_i  (start && !busy),
        .en_i   (beat && (state_q != S_CHK)),
        .data_i (s_if.in_data),
        .acc_o  (acc)
    );
    assign s_final = S_CHK;
`else
    assign s_final = S_DONE;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen_d    = 1'b0;
        addr2_d  = addr2_q;
        wdata2_d = wdata2_q;
        wen2_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_I_CNT;
            S_I_CNT: if (beat) begin
                if (s_if.in_data > 32'(IMEM_DEPTH))
                    state_d = S_ERR;
                else if (s_if.in_data == '0)
                    state_d = S_D_CNT;
                else begin
                    cnt_d   = s_if.in_data;
                    idx_d   = '0;
                    state_d = S_I_WORD;
                end
            end
            S_I_WORD: if (beat) begin
                wen_d   = 1'b1;
                addr_d  = 64'(idx_q) * 64'(IMEM_WORD_BYTES);
                wdata_d = s_if.in_data;
                idx_d   = idx_inc;
                if (last) state_d = S_D_CNT;
            end
            S_D_CNT: if (beat) begin
                if (s_if.in_data > 32'(DMEM_DEPTH))
                    state_d = S_ERR;
                else if (s_if.in_data == '0)
                    state_d = s_final;
                else begin
                    cnt_d   = s_if.in_data;
                    idx_d   = '0;
                    state_d = S_D_LO;
                end
            end
            S_D_LO: if (beat) begin
                lo_d    = s_if.in_data;
                state_d = S_D_HI;
            end
            S_D_HI: if (beat) begin
                wen2_d   = 1'b1;
                addr2_d  = 64'(idx_q) * 64'(DMEM_WORD_BYTES);
                wdata2_d = {s_if.in_data, lo_q};
                idx_d    = idx_inc;
                state_d  = last ? s_final : S_D_LO;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK: if (beat) state_d = (s_if.in_data == acc) ? S_DONE : S_ERR;
`endif
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            lo_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            addr2_q  <= '0;
            wdata2_q <= '0;
            wen2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lo_q     <= lo_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
            addr2_q  <= addr2_d;
            wdata2_q <= wdata2_d;
            wen2_q   <= wen2_d;
        end
    end

    assign s_if.in_ready = busy;
    assign error         = (state_q == S_ERR);
    assign cpu_enable    = (state_q == S_DONE);
    assign addr_ext      = addr_q;
    assign wen_ext       = wen_q;
    assign ren_ext       = 1'b0;
    assign wdata_ext     = wdata_q;
    assign addr_ext_2    = addr2_q;
    assign wen_ext_2     = wen2_q;
    assign ren_ext_2     = 1'b0;
    assign wdata_ext_2   = wdata2_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader stream loading
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic        busy, error, cpu_enable;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] wdata_ext;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;

    prog_loader_if sif ();

    prog_loader dut (
        .clk         (clk),
        .arst        (arst),
        .start       (start),
        .s_if        (sif),
        .busy        (busy),
        .error       (error),
        .cpu_enable  (cpu_enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           imem_wr_cnt = 0;
    int           dmem_wr_cnt = 0;
    logic [95:0]  iq[$];
    logic [127:0] dq[$];
    logic [95:0]  iexp;
    logic [127:0] dexp;

    always @(negedge clk) begin
        if (wen_ext === 1'b1) begin
            imem_wr_cnt++;
            n_checks++;
            if (iq.size() == 0) begin
                n_fail++;
                $display("FAIL imem_unexpected_write addr=%h data=%h expected no write", addr_ext, wdata_ext);
            end else begin
                iexp = iq.pop_front();
                if ({addr_ext, wdata_ext} !== iexp) begin
                    n_fail++;
                    $display("FAIL imem_write got addr=%h data=%h expected addr=%h data=%h",
                             addr_ext, wdata_ext, iexp[95:32], iexp[31:0]);
                end
            end
        end
        if (wen_ext_2 === 1'b1) begin
            dmem_wr_cnt++;
            n_checks++;
            if (dq.size() == 0) begin
                n_fail++;
                $display("FAIL dmem_unexpected_write addr=%h data=%h expected no write", addr_ext_2, wdata_ext_2);
            end else begin
                dexp = dq.pop_front();
                if ({addr_ext_2, wdata_ext_2} !== dexp) begin
                    n_fail++;
                    $display("FAIL dmem_write got addr=%h data=%h expected addr=%h data=%h",
                             addr_ext_2, wdata_ext_2, dexp[127:64], dexp[63:0]);
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        sif.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] w, input bit gaps);
        int budget;
        budget = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1 && budget < 8) begin
                sif.in_valid = 1'b0;
                @(negedge clk);
                budget++;
            end
        end
        sif.in_valid = 1'b1;
        sif.in_data  = w;
        budget = 0;
        while (!sif.in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!sif.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout in_ready=%b expected 1 for word %h", sif.in_ready, w);
        end
        @(negedge clk);
        sif.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        n_checks++;
        if ({busy, error, cpu_enable, sif.in_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
             addr_ext, wdata_ext, addr_ext_2, wdata_ext_2} !== '0) begin
            n_fail++;
            $display("FAIL reset_initial busy=%b err=%b en=%b rdy=%b addr=%h expected all 0",
                     busy, error, cpu_enable, sif.in_ready, addr_ext);
        end
        arst = 1'b0;
        @(negedge clk);
        base = imem_wr_cnt;
        pulse_start();
        iq.push_back({64'd4, 32'hA5A5_0001});
        iq.push_back({64'd8, 32'hA5A5_0002});
        iq.push_front({64'd0, 32'hA5A5_0000});
        send(32'd4, 1'b0);
        send(32'hA5A5_0000, 1'b0);
        send(32'hA5A5_0001, 1'b0);
        send(32'hA5A5_0002, 1'b0);
        sif.in_valid = 1'b1;
        sif.in_data  = 32'hA5A5_0003;
        arst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, error, cpu_enable, sif.in_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
             addr_ext, wdata_ext, addr_ext_2, wdata_ext_2} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_load busy=%b rdy=%b wen=%b addr=%h data=%h expected all 0",
                     busy, sif.in_ready, wen_ext, addr_ext, wdata_ext);
        end
        arst = 1'b0;
        repeat (5) @(negedge clk);
        sif.in_valid = 1'b0;
        n_checks++;
        if (imem_wr_cnt - base !== 3 || iq.size() != 0) begin
            n_fail++;
            $display("FAIL reset_write_count got %0d writes (%0d pending) expected 3 (0)",
                     imem_wr_cnt - base, iq.size());
        end
    endtask

    task automatic test_basic(input bit gaps, input bit wrong_csum);
        logic [31:0] s[$];
        logic [31:0] csum;
        s = '{32'd2, 32'h0050_0093, 32'h0010_0113, 32'd1, 32'hDEAD_BEEF, 32'h0123_4567};
        csum = '0;
        foreach (s[i]) csum ^= s[i];
        pulse_start();
        n_checks++;
        if ({busy, cpu_enable, error} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_start busy/en/err=%b expected 100", {busy, cpu_enable, error});
        end
        iq.push_back({64'd0, 32'h0050_0093});
        iq.push_back({64'd4, 32'h0010_0113});
        dq.push_back({64'd0, 64'h0123_4567_DEAD_BEEF});
        foreach (s[i]) send(s[i], gaps);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(wrong_csum ? (csum ^ 32'h0000_0100) : csum, gaps);
`endif
        n_checks++;
        if ({cpu_enable, error, busy} !== {!wrong_csum, wrong_csum, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_end en/err/busy=%b expected %b",
                     {cpu_enable, error, busy}, {!wrong_csum, wrong_csum, 1'b0});
        end
        @(negedge clk);
        n_checks++;
        if (iq.size() != 0 || dq.size() != 0) begin
            n_fail++;
            $display("FAIL basic_lost_writes pending imem=%0d dmem=%0d expected 0 0", iq.size(), dq.size());
        end
    endtask

    task automatic test_zero_counts();
        int bi, bd;
        bi = imem_wr_cnt;
        bd = dmem_wr_cnt;
        pulse_start();
        send(32'd0, 1'b0);
        send(32'd0, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(32'd0, 1'b0);
`endif
        n_checks++;
        if ({cpu_enable, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_done en/busy=%b expected 10", {cpu_enable, busy});
        end
        @(negedge clk);
        n_checks++;
        if (imem_wr_cnt != bi || dmem_wr_cnt != bd) begin
            n_fail++;
            $display("FAIL zero_writes got %0d/%0d expected 0/0", imem_wr_cnt - bi, dmem_wr_cnt - bd);
        end
    endtask

    task automatic test_overflow();
        int bi;
        do_reset();
        bi = imem_wr_cnt;
        pulse_start();
        send(32'd513, 1'b0);
        n_checks++;
        if ({error, sif.in_ready, busy, cpu_enable} !== 4'b1000) begin
            n_fail++;
            $display("FAIL icnt_overflow err/rdy/busy/en=%b expected 1000",
                     {error, sif.in_ready, busy, cpu_enable});
        end
        pulse_start();
        n_checks++;
        if ({error, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL overflow_restart err/busy=%b expected 01", {error, busy});
        end
        send(32'd0, 1'b0);
        send(32'd1025, 1'b0);
        n_checks++;
        if ({error, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL dcnt_overflow err/busy=%b expected 10", {error, busy});
        end
        pulse_start();
        send(32'd512, 1'b0);
        n_checks++;
        if ({error, busy, sif.in_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL icnt_at_depth err/busy/rdy=%b expected 011", {error, busy, sif.in_ready});
        end
        n_checks++;
        if (imem_wr_cnt != bi) begin
            n_fail++;
            $display("FAIL overflow_writes got %0d expected 0", imem_wr_cnt - bi);
        end
        do_reset();
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic(1'b0, 1'b0);
        test_basic(1'b1, 1'b0);
        test_basic(1'b1, 1'b0);
        test_zero_counts();
        test_overflow();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_basic(1'b0, 1'b1);
        test_basic(1'b1, 1'b0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
